// File: rtl/mix_column_sequencer_pkg.sv
// Shared types and constants for the MixColumns sequencer: FSM states and the
// forward and inverse MixColumns coefficient rows.
package mix_column_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] MC_ENC_COEF0 = 8'h02;
  localparam logic [7:0] MC_ENC_COEF1 = 8'h03;
  localparam logic [7:0] MC_ENC_COEF2 = 8'h01;
  localparam logic [7:0] MC_ENC_COEF3 = 8'h01;
  localparam logic [7:0] MC_DEC_COEF0 = 8'h0E;
  localparam logic [7:0] MC_DEC_COEF1 = 8'h0B;
  localparam logic [7:0] MC_DEC_COEF2 = 8'h0D;
  localparam logic [7:0] MC_DEC_COEF3 = 8'h09;

  localparam logic [7:0] GF_POLY_LOW = 8'h1B;

  // Coefficient for circulant position idx = (j - i) mod 4.
  function automatic logic [7:0] coef_sel(input logic dec, input logic [1:0] idx);
    logic [7:0] c;
    case ({dec, idx})
      3'b0_00: c = MC_ENC_COEF0;
      3'b0_01: c = MC_ENC_COEF1;
      3'b0_10: c = MC_ENC_COEF2;
      3'b0_11: c = MC_ENC_COEF3;
      3'b1_00: c = MC_DEC_COEF0;
      3'b1_01: c = MC_DEC_COEF1;
      3'b1_10: c = MC_DEC_COEF2;
      3'b1_11: c = MC_DEC_COEF3;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mix_column_sequencer_gf_mul.sv
// Combinational GF(2^8) multiplier over the AES field (poly 0x11B),
// shift-and-add form: out = in1 * in2.
module mix_column_sequencer_gf_mul
  import mix_column_sequencer_pkg::*;
(
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  output logic [7:0] out
);

  logic [7:0] part;
  logic [7:0] shifted;

  // Accumulate in1 * x^k for every set bit k of in2, reducing as in1 is shifted.
  always_comb begin
    part    = 8'h00;
    shifted = in1;
    for (int k = 0; k < 8; k++) begin
      if (in2[k]) begin
        part = part ^ shifted;
      end else begin
        part = part;
      end
      shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? GF_POLY_LOW : 8'h00);
    end
    out = part;
  end

endmodule

// File: rtl/mix_column_sequencer.sv
// AES MixColumns / InvMixColumns on one column, time-sharing a single GF(2^8)
// multiplier over 16 cycles with valid/ready handshakes on both sides.
module mix_column_sequencer
  import mix_column_sequencer_pkg::*;
#(
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] col_in,
  input  logic        dec_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] col_out,
  output logic        busy
);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [7:0]  acc_r;
  logic [7:0]  a_r [0:3];
  logic        dec_r;

  logic [1:0]  row_s;
  logic [1:0]  byte_s;
  logic [7:0]  coef_s;
  logic [7:0]  operand_s;
  logic [7:0]  prod_s;
  logic [7:0]  row_sum_s;

  assign row_s  = cnt_r[3:2];
  assign byte_s = cnt_r[1:0];

  // Select the circulant coefficient and input byte for this cycle's product.
  always_comb begin
    coef_s    = coef_sel(dec_r, byte_s - row_s);
    operand_s = a_r[byte_s];
    row_sum_s = acc_r ^ prod_s;
  end

  mix_column_sequencer_gf_mul u_gf_mul (
    .in1 (coef_s),
    .in2 (operand_s),
    .out (prod_s)
  );

  // Control FSM with datapath registers; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      acc_r     <= 8'h00;
      dec_r     <= 1'b0;
      col_out   <= 32'h0000_0000;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        a_r[k] <= 8'h00;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_r[0]   <= col_in[31:24];
            a_r[1]   <= col_in[23:16];
            a_r[2]   <= col_in[15:8];
            a_r[3]   <= col_in[7:0];
            dec_r    <= dec_in & DECRYPT_EN;
            cnt_r    <= 4'd0;
            acc_r    <= 8'h00;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= ST_MUL;
          end
        end
        ST_MUL: begin
          cnt_r <= cnt_r + 4'd1;
          if (byte_s != 2'd3) begin
            acc_r <= row_sum_s;
          end else begin
            acc_r <= 8'h00;
            // Last product of a row: the finished byte lands in its col_out lane.
            case (row_s)
              2'd0:    col_out[31:24] <= row_sum_s;
              2'd1:    col_out[23:16] <= row_sum_s;
              2'd2:    col_out[15:8]  <= row_sum_s;
              2'd3:    col_out[7:0]   <= row_sum_s;
              default: col_out        <= col_out;
            endcase
          end
          if (cnt_r == 4'd15) begin
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Input is only taken from IDLE, so a concurrent in_valid waits a cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_column_sequencer.sv
// Scoreboard bench for mix_column_sequencer: a decrypt-capable and an
// encrypt-only instance share stimulus and are checked against a matrix model.
module tb_mix_column_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] col_in = 32'h0;
  logic        dec_in = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, busy;
  logic [31:0] col_out;
  logic        e_in_ready, e_out_valid, e_busy;
  logic [31:0] e_col_out;

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;
  bit rand_done = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_e_q[$];

  typedef enum {M_IDLE, M_MUL, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_cnt = 0;
  bit      rst_seen = 1'b0;

  mix_column_sequencer #(.DECRYPT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .col_in(col_in), .dec_in(dec_in), .out_valid(out_valid),
    .out_ready(out_ready), .col_out(col_out), .busy(busy)
  );

  mix_column_sequencer #(.DECRYPT_EN(1'b0)) u_enc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
    .col_in(col_in), .dec_in(dec_in), .out_valid(e_out_valid),
    .out_ready(out_ready), .col_out(e_col_out), .busy(e_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a MixColumns coefficient using xtime decompositions.
  function automatic logic [7:0] gmul(input logic [7:0] b, input int c);
    logic [7:0] x1, x2, x3;
    x1 = xt(b); x2 = xt(x1); x3 = xt(x2);
    case (c)
      1:       return b;
      2:       return x1;
      3:       return x1 ^ b;
      9:       return x3 ^ b;
      11:      return x3 ^ x1 ^ b;
      13:      return x3 ^ x2 ^ b;
      14:      return x3 ^ x2 ^ x1;
      default: return 8'h00;
    endcase
  endfunction

  // Circulant matrix product: b[r] = sum_t k[t] * a[(r+t) mod 4].
  function automatic logic [31:0] mixcol(input logic [31:0] c, input bit inv);
    logic [7:0] a[4];
    logic [7:0] b[4];
    int k[4];
    if (inv) begin
      k[0] = 14; k[1] = 11; k[2] = 13; k[3] = 9;
    end else begin
      k[0] = 2; k[1] = 3; k[2] = 1; k[3] = 1;
    end
    a[0] = c[31:24]; a[1] = c[23:16]; a[2] = c[15:8]; a[3] = c[7:0];
    for (int r = 0; r < 4; r++) begin
      b[r] = 8'h00;
      for (int t = 0; t < 4; t++) b[r] = b[r] ^ gmul(a[(r + t) % 4], k[t]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  // Behavioural model of the handshake timeline; pushes expected columns on accept.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst) begin
      m_state  <= M_IDLE;
      m_cnt    <= 0;
      rst_seen <= 1'b1;
      exp_q.delete();
      exp_e_q.delete();
    end else begin
      rst_seen <= 1'b0;
      case (m_state)
        M_IDLE: if (in_valid) begin
          exp_q.push_back(mixcol(col_in, dec_in));
          exp_e_q.push_back(mixcol(col_in, 1'b0));
          m_cnt   <= 0;
          m_state <= M_MUL;
        end
        M_MUL: if (m_cnt == 15) m_state <= M_DONE; else m_cnt <= m_cnt + 1;
        M_DONE: if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_e_q.pop_front());
          m_state <= M_IDLE;
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  // Monitor: compare DUT outputs with the model away from the clock edge.
  always @(negedge clk) begin
    if (cycle > 0) begin
      chk("in_ready",    {31'b0, in_ready},    {31'b0, m_state == M_IDLE});
      chk("out_valid",   {31'b0, out_valid},   {31'b0, m_state == M_DONE});
      chk("busy",        {31'b0, busy},        {31'b0, m_state != M_IDLE});
      chk("e_in_ready",  {31'b0, e_in_ready},  {31'b0, m_state == M_IDLE});
      chk("e_out_valid", {31'b0, e_out_valid}, {31'b0, m_state == M_DONE});
      if (rst_seen) begin
        chk("reset_col_out",   col_out,   32'h0);
        chk("reset_e_col_out", e_col_out, 32'h0);
      end
      if (m_state == M_DONE && exp_q.size() > 0) begin
        chk("col_out",   col_out,   exp_q[0]);
        chk("e_col_out", e_col_out, exp_e_q[0]);
      end
    end
  end

  task automatic wait_accept();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) begin
      fails++;
      $display("FAIL accept_timeout at cycle %0d: got no in_ready, expected in_ready within 200 cycles", cycle);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] c, input logic d);
    @(posedge clk); #1;
    in_valid = 1'b1; col_in = c; dec_in = d;
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (m_state == M_IDLE && exp_q.size() == 0 && !in_valid) break;
    end
    if (n == 300) begin
      fails++;
      $display("FAIL drain_timeout at cycle %0d: got %0d pending, expected 0", cycle, exp_q.size());
    end
  endtask

  initial begin
    chk("model_enc_vector", mixcol(32'hDB135345, 1'b0), 32'h8E4DA1BC);
    chk("model_dec_vector", mixcol(32'h8E4DA1BC, 1'b1), 32'hDB135345);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(32'hDB135345, 1'b0);
    wait_idle();

    send(32'hF20A225C, 1'b0);
    send(32'hC6C6C6C6, 1'b0);
    send(32'h01010101, 1'b0);
    wait_idle();

    send(32'h8E4DA1BC, 1'b1);
    wait_idle();

    out_ready = 1'b0;
    send(32'h2D26314C, 1'b0);
    repeat (36) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    send(32'hDB135345, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(32'hDB135345, 1'b0);
    wait_idle();

    @(posedge clk); #1;
    in_valid = 1'b1; col_in = 32'hD4D4D4D5; dec_in = 1'b0;
    wait_accept();
    for (int k = 0; k < 15; k++) begin
      col_in = $urandom; dec_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    fork
      begin
        for (int k = 0; k < 30; k++) send($urandom, 1'($urandom_range(0, 1)));
        wait_idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
